// File: rtl/femto_sdram_bridge.sv
`timescale 1ns/1ps
// femto_sdram_bridge
// Bridges the FemtoRV32 memory port to the sdram controller's valid/ready port.
// A selected CPU strobe latches the request and raises valid. Valid is held
// until the controller answers or the timeout expires. The bridge then waits
// for ready to fall before it accepts another request. Read data is captured
// for the CPU. Protocol violations and timeouts raise a sticky bus_err.
module femto_sdram_bridge #(
   parameter logic [3:0]  SDRAM_BASE     = 4'h4,  // mem_addr[31:28] value that selects SDRAM
   parameter int unsigned TIMEOUT_CYCLES = 1024   // cycles in REQ before abort, legal 2..65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_rbusy,
   output logic        mem_wbusy,
   output logic [24:0] sdram_addr,
   output logic [31:0] sdram_din,
   output logic [3:0]  sdram_wmask,
   output logic        sdram_valid,
   input  logic [31:0] sdram_dout,
   input  logic        sdram_ready,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,  // waiting for a selected CPU strobe
      ST_REQ     = 2'd1,  // valid asserted toward the controller
      ST_RELEASE = 2'd2   // transfer done, waiting for ready to drop
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] ABORT_RDATA  = 32'hDEAD_BEEF;

   state_t      state;
   logic        op_write;     // the in-flight transfer is a write
   logic [15:0] timeout_cnt;  // cycles spent in REQ, cleared on entry

   logic sel;
   logic strobe;

   // Address bits outside the decode window and the word offset are not used.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[27:25], mem_addr[1:0]};

   assign sel    = (mem_addr[31:28] == SDRAM_BASE);
   assign strobe = sel & (mem_rstrb | (|mem_wmask));

   // NOTE: busy is a pure decode of state and op_write. No CPU input can
   // ripple through to the CPU's stall inputs in the same cycle. Reset drops
   // busy at once because both source registers clear asynchronously.
   assign mem_rbusy = (state != ST_IDLE) & ~op_write;
   assign mem_wbusy = (state != ST_IDLE) &  op_write;

   // Request FSM: accept, hold valid until ready or timeout, then wait for ready to release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_write    <= 1'b0;
         timeout_cnt <= 16'd0;
         mem_rdata   <= 32'd0;
         sdram_addr  <= 25'd0;
         sdram_din   <= 32'd0;
         sdram_wmask <= 4'd0;
         sdram_valid <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         // NOTE: every assignment here is non-blocking. All registers update
         // together from the values they held before the edge, so the order of
         // the statements below does not change the behaviour.
         case (state)
            ST_IDLE: begin
               if (strobe) begin
                  sdram_addr  <= {mem_addr[24:2], 2'b00};
                  sdram_din   <= mem_wdata;
                  // A read carries an all-zero mask already. A write mask wins when both strobes fire.
                  sdram_wmask <= mem_wmask;
                  op_write    <= |mem_wmask;
                  timeout_cnt <= 16'd0;
                  sdram_valid <= 1'b1;
                  state       <= ST_REQ;
               end
            end

            ST_REQ: begin
               if (strobe) begin
                  bus_err <= 1'b1;  // the CPU broke the one-outstanding-request rule
               end
               if (sdram_ready) begin
                  if (!op_write) begin
                     mem_rdata <= sdram_dout;
                  end
                  sdram_valid <= 1'b0;
                  state       <= ST_RELEASE;
               end else if (timeout_cnt == TIMEOUT_LAST) begin
                  bus_err <= 1'b1;
                  if (!op_write) begin
                     mem_rdata <= ABORT_RDATA;
                  end
                  sdram_valid <= 1'b0;
                  state       <= ST_RELEASE;
               end else begin
                  timeout_cnt <= timeout_cnt + 16'd1;
               end
            end

            ST_RELEASE: begin
               if (strobe) begin
                  bus_err <= 1'b1;
               end
               // A stretched ready must not complete the next request early.
               if (!sdram_ready) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state       <= ST_IDLE;
               sdram_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_femto_sdram_bridge.sv
`timescale 1ns/1ps
// tb_femto_sdram_bridge
// Transaction-level reference model: each request is described by its
// controller latency and ready hold time. The expected valid/busy durations,
// latched fields, read data and error flag are derived from those numbers.
module tb_femto_sdram_bridge;

   localparam int T = 8;  // TIMEOUT_CYCLES used for the whole run

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wmask = 4'd0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic        mem_rbusy;
   logic        mem_wbusy;
   logic [24:0] sdram_addr;
   logic [31:0] sdram_din;
   logic [3:0]  sdram_wmask;
   logic        sdram_valid;
   logic [31:0] sdram_dout = 32'd0;
   logic        sdram_ready = 1'b0;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   // Model state that persists across transactions.
   logic [31:0] exp_rdata = 32'd0;
   logic        exp_err = 1'b0;

   femto_sdram_bridge #(
      .SDRAM_BASE(4'h4),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask),
      .mem_rstrb(mem_rstrb),
      .mem_rdata(mem_rdata),
      .mem_rbusy(mem_rbusy),
      .mem_wbusy(mem_wbusy),
      .sdram_addr(sdram_addr),
      .sdram_din(sdram_din),
      .sdram_wmask(sdram_wmask),
      .sdram_valid(sdram_valid),
      .sdram_dout(sdram_dout),
      .sdram_ready(sdram_ready),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // One CPU access plus a controller response.
   // d     : cycles valid stays high before ready is driven (d+1 > T means no answer)
   // h     : number of cycles ready is held high
   // extra : issue one more read strobe somewhere inside the busy window
   // The task starts and ends 1 time unit after a rising edge.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic rstrb,
                          input int d, input int h, input logic [31:0] rd_val,
                          input bit extra, input int s_seed, input bit extra_sel,
                          input string tag);
      bit          sel, is_wr, tmo, unstable;
      int          exp_v, exp_b, s, i, v_cnt, rb_cnt, wb_cnt;
      logic [24:0] e_addr;
      logic [3:0]  e_mask;
      sel    = (addr[31:28] == 4'h4);
      is_wr  = (wmask != 4'd0);
      tmo    = (d + 1 > T);
      exp_v  = tmo ? T : d + 1;
      exp_b  = tmo ? T + 1 : d + h + 1;
      s      = s_seed % exp_b;
      e_addr = {addr[24:2], 2'b00};
      e_mask = is_wr ? wmask : 4'b0000;

      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wmask = wmask;
      mem_rstrb = rstrb;
      @(posedge clk); #1;
      mem_wmask = 4'd0;
      mem_rstrb = 1'b0;

      if (!sel) begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if ({sdram_valid, mem_rbusy, mem_wbusy} !== 3'b000) begin
               errors++;
               $display("FAIL %s idle_outputs: valid/rbusy/wbusy=%b expected 000", tag,
                        {sdram_valid, mem_rbusy, mem_wbusy});
            end
            @(posedge clk); #1;
         end
         checks++;
         if (bus_err !== exp_err) begin
            errors++;
            $display("FAIL %s bus_err: got %b expected %b", tag, bus_err, exp_err);
         end
         return;
      end

      checks++;
      if (sdram_addr !== e_addr) begin
         errors++;
         $display("FAIL %s sdram_addr: got %h expected %h", tag, sdram_addr, e_addr);
      end
      checks++;
      if (sdram_din !== wdata) begin
         errors++;
         $display("FAIL %s sdram_din: got %h expected %h", tag, sdram_din, wdata);
      end
      checks++;
      if (sdram_wmask !== e_mask) begin
         errors++;
         $display("FAIL %s sdram_wmask: got %b expected %b", tag, sdram_wmask, e_mask);
      end

      i = 0; v_cnt = 0; rb_cnt = 0; wb_cnt = 0; unstable = 0;
      while (i < 200) begin
         if (sdram_valid === 1'b1) begin
            v_cnt++;
            if (sdram_addr !== e_addr || sdram_din !== wdata || sdram_wmask !== e_mask)
               unstable = 1;
         end
         if (mem_rbusy === 1'b1) rb_cnt++;
         if (mem_wbusy === 1'b1) wb_cnt++;
         if (mem_rbusy !== 1'b1 && mem_wbusy !== 1'b1) break;
         sdram_ready = !tmo && (i >= d) && (i < d + h);
         sdram_dout  = sdram_ready ? rd_val : $urandom;
         if (extra && i == s) begin
            mem_rstrb = 1'b1;
            mem_addr  = extra_sel ? {4'h4, 28'($urandom)} : {4'h1, 28'($urandom)};
         end
         @(posedge clk); #1;
         i++;
         mem_rstrb = 1'b0;
         mem_addr  = addr;
      end
      sdram_ready = 1'b0;

      if (tmo || (extra && extra_sel)) exp_err = 1'b1;
      if (!is_wr) exp_rdata = tmo ? 32'hDEAD_BEEF : rd_val;

      checks++;
      if (v_cnt != exp_v) begin
         errors++;
         $display("FAIL %s valid_cycles: got %0d expected %0d", tag, v_cnt, exp_v);
      end
      checks++;
      if (rb_cnt != (is_wr ? 0 : exp_b)) begin
         errors++;
         $display("FAIL %s rbusy_cycles: got %0d expected %0d", tag, rb_cnt, is_wr ? 0 : exp_b);
      end
      checks++;
      if (wb_cnt != (is_wr ? exp_b : 0)) begin
         errors++;
         $display("FAIL %s wbusy_cycles: got %0d expected %0d", tag, wb_cnt, is_wr ? exp_b : 0);
      end
      checks++;
      if (unstable) begin
         errors++;
         $display("FAIL %s request_stable: latched fields changed while valid", tag);
      end
      checks++;
      if (mem_rdata !== exp_rdata) begin
         errors++;
         $display("FAIL %s mem_rdata: got %h expected %h", tag, mem_rdata, exp_rdata);
      end
      checks++;
      if (bus_err !== exp_err) begin
         errors++;
         $display("FAIL %s bus_err: got %b expected %b", tag, bus_err, exp_err);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({sdram_valid, mem_rbusy, mem_wbusy, bus_err, sdram_wmask, sdram_addr, sdram_din, mem_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_values: valid=%b rbusy=%b wbusy=%b err=%b wmask=%b addr=%h din=%h rdata=%h expected all 0",
                  sdram_valid, mem_rbusy, mem_wbusy, bus_err, sdram_wmask, sdram_addr, sdram_din, mem_rdata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      run_txn(32'h4000_0104, 32'h0, 4'b0000, 1'b1, 5, 1, 32'h1234_5678, 0, 0, 0, "read");
      checks++;
      if (sdram_addr !== 25'h000_0104) begin
         errors++;
         $display("FAIL read_addr_const: got %h expected 0000104", sdram_addr);
      end
   endtask

   task automatic test_write();
      run_txn(32'h4012_3456, 32'hCAFE_0000, 4'b1100, 1'b0, 2, 1, 32'h5555_AAAA, 0, 0, 0, "write");
      checks++;
      if (sdram_addr !== 25'h012_3454) begin
         errors++;
         $display("FAIL write_addr_const: got %h expected 0123454", sdram_addr);
      end
   endtask

   task automatic test_unselected();
      run_txn(32'h2000_0000, 32'h0, 4'b0000, 1'b1, 0, 1, 32'h0, 0, 0, 0, "unselected");
   endtask

   task automatic test_timeout();
      run_txn(32'h4000_0200, 32'h0, 4'b0000, 1'b1, 100, 1, 32'h0, 0, 0, 0, "timeout");
   endtask

   task automatic test_stretched_ready();
      // Ready is high for 3 cycles. The second strobe lands while the bridge is in RELEASE.
      run_txn(32'h4000_0300, 32'h0, 4'b0000, 1'b1, 1, 3, 32'h0BAD_F00D, 1, 3, 1, "stretched");
   endtask

   task automatic test_back_to_back();
      run_txn(32'h4000_1000, 32'h1111_1111, 4'b1111, 1'b0, 0, 1, 32'h0, 0, 0, 0, "b2b_w");
      run_txn(32'h4000_1004, 32'h0, 4'b0000, 1'b1, 0, 1, 32'h7777_8888, 0, 0, 0, "b2b_r");
      run_txn(32'h4000_1008, 32'h2222_2222, 4'b0011, 1'b1, 0, 2, 32'h0, 0, 0, 0, "b2b_rw");
   endtask

   task automatic test_reset_mid();
      mem_addr  = 32'h4000_0040;
      mem_wdata = 32'hA5A5_A5A5;
      mem_wmask = 4'b1111;
      @(posedge clk); #1;
      mem_wmask = 4'd0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checks++;
      if (sdram_valid !== 1'b0 || mem_wbusy !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: valid=%b wbusy=%b expected 0 0 before clk", sdram_valid, mem_wbusy);
      end
      checks++;
      if ({mem_rbusy, bus_err, sdram_wmask, sdram_addr, sdram_din, mem_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_mid_values: rbusy=%b err=%b wmask=%b addr=%h din=%h rdata=%h expected all 0",
                  mem_rbusy, bus_err, sdram_wmask, sdram_addr, sdram_din, mem_rdata);
      end
      exp_err   = 1'b0;
      exp_rdata = 32'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      run_txn(32'h4000_0044, 32'h0, 4'b0000, 1'b1, 3, 1, 32'h600D_DA7A, 0, 0, 0, "after_reset");
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic [3:0]  wmask;
      logic        rstrb;
      int          kind;
      for (int n = 0; n < 40; n++) begin
         addr = $urandom;
         if ($urandom_range(0, 4) != 0) addr[31:28] = 4'h4;
         kind  = $urandom_range(0, 2);
         wmask = (kind == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         rstrb = (kind != 1);
         run_txn(addr, $urandom, wmask, rstrb, $urandom_range(0, 9), $urandom_range(1, 3),
                 $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 1000),
                 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_unselected();
      test_back_to_back();
      test_timeout();
      test_stretched_ready();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/femto_sdram_bridge.md
# femto_sdram_bridge

Bus bridge between the FemtoRV32 memory port and the `sdram` controller's valid/ready port. It decodes the SDRAM address window and latches address, write data and write mask on a CPU strobe. It holds `valid` toward the controller until completion and drives `mem_rbusy`/`mem_wbusy` back to the CPU. It also captures read data and aborts hung transfers with a timeout and a sticky error flag.

## Interface
- `SDRAM_BASE`, default `4'h4`: value of `mem_addr[31:28]` that selects SDRAM.
- `TIMEOUT_CYCLES`, default `1024`: maximum cycles in REQ before abort. Legal range 2..65535.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: **asynchronous, active-high** reset.
- `mem_addr` in 32: CPU byte address.
- `mem_wdata` in 32: CPU write data.
- `mem_wmask` in 4: CPU write strobe/byte mask; non-zero for one cycle per write.
- `mem_rstrb` in 1: CPU read strobe; one-cycle pulse.
- `mem_rdata` out 32: read data to CPU.
- `mem_rbusy` out 1: read in progress.
- `mem_wbusy` out 1: write in progress.
- `sdram_addr` out 25: `{mem_addr[24:2], 2'b00}`, latched.
- `sdram_din` out 32: latched write data.
- `sdram_wmask` out 4: latched mask; `4'b0000` for reads.
- `sdram_valid` out 1: request valid.
- `sdram_dout` in 32: controller read data, valid while `sdram_ready`=1.
- `sdram_ready` in 1: controller completion; high ≥1 cycle per transfer.
- `bus_err` out 1: sticky error (timeout or strobe while busy).

## Operation
- Select: `sel = (mem_addr[31:28] == SDRAM_BASE)`. Strobes with `sel`=0 are ignored and cause no busy.
- Accept: in IDLE, on `sel & (mem_rstrb | |mem_wmask)`:
  - latch addr, wdata, and mask (forced to 0 if the access is a read);
  - set `op_write = |mem_wmask`; write wins if both strobes are asserted;
  - go to REQ.
- States:
  - IDLE: `sdram_valid`=0, busy=0.
  - REQ: `sdram_valid`=1; timeout counter increments each cycle.
    - `sdram_ready`=1: capture `sdram_dout` into `mem_rdata` (reads only) and go to RELEASE.
    - Counter reaches `TIMEOUT_CYCLES`-1 with `sdram_ready`=0: set `bus_err`, load `mem_rdata`=`32'hDEAD_BEEF` (reads only), go to RELEASE.
  - RELEASE: `sdram_valid`=0. Stay until `sdram_ready`=0 is sampled, then go to IDLE. This prevents a stretched ready from completing a new request early.
- Busy outputs:
  - `mem_rbusy = (state != IDLE) & ~op_write`.
  - `mem_wbusy = (state != IDLE) & op_write`.
  - Both are decoded from registers only.
- Strobe arriving in REQ/RELEASE (selected): ignored, sets `bus_err`, in-flight transfer unaffected.
- `mem_rdata` holds its last value between reads and is unchanged by writes.
- `bus_err` clears only on `reset`.
- Reset mid-transfer: immediate return to IDLE, `sdram_valid` drops asynchronously, latched request discarded.

## Timing
- Reset values: state IDLE, `mem_rdata`=0, `mem_rbusy`=0, `mem_wbusy`=0, `sdram_valid`=0, `sdram_addr`=0, `sdram_din`=0, `sdram_wmask`=0, `bus_err`=0, counter 0.
- Strobe sampled at edge E0 → `sdram_valid` and busy high after E0. The CPU sees busy on the cycle after its strobe.
- `sdram_ready` sampled high at edge Ek → `sdram_valid` low and `mem_rdata` updated after Ek.
- `sdram_ready` sampled low at edge Em (m > k) → busy low after Em.
- Minimum bridge overhead is 2 cycles beyond controller latency. For a one-cycle ready pulse, busy falls one cycle after `valid`.
- Next strobe is accepted at the first edge after busy falls. Back-to-back requests have no extra bubble.
- Timeout counter is 16 bits and cleared on entering REQ. Abort occurs exactly `TIMEOUT_CYCLES` cycles after `valid` rises.
- Outputs `sdram_addr`, `sdram_din` and `sdram_wmask` are stable for the whole REQ state.

## Test plan
- Read, selected:
  - Stimulus: `mem_addr`=`32'h4000_0104`, `mem_rstrb` pulse; `sdram_ready` pulses for 1 cycle, 5 cycles after valid, with `sdram_dout`=`32'h1234_5678`.
  - Required: `sdram_addr`=`25'h000_0104`, `sdram_wmask`=0, `mem_rbusy` high for 7 cycles, `mem_wbusy`=0, `mem_rdata`=`32'h1234_5678`.
- Write, selected:
  - Stimulus: `mem_addr`=`32'h4012_3456`, `mem_wmask`=`4'b1100`, `mem_wdata`=`32'hCAFE_0000`.
  - Required: `sdram_addr`=`25'h012_3454`, `sdram_din`=`32'hCAFE_0000`, `sdram_wmask`=`4'b1100`, `mem_wbusy` high until ready is released, `mem_rdata` unchanged.
- Unselected access:
  - Stimulus: `mem_addr`=`32'h2000_0000` with `mem_rstrb`.
  - Required: `sdram_valid`, `mem_rbusy` and `mem_wbusy` stay 0.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=8, read with `sdram_ready` held 0.
  - Required: `sdram_valid` high exactly 8 cycles, `bus_err`=1, `mem_rdata`=`32'hDEAD_BEEF`, busy low 1 cycle later.
- Stretched ready and strobe-while-busy:
  - Stimulus: hold `sdram_ready` high 3 cycles; issue a second read strobe during RELEASE.
  - Required: valid low after the first ready edge, busy held until ready falls, second strobe ignored, `bus_err`=1.
- Reset mid-REQ:
  - Stimulus: assert `reset` 2 cycles into a write.
  - Required: `sdram_valid` and `mem_wbusy` drop without waiting for `clk`; all outputs at reset values; a subsequent read completes normally.
